// File: rtl/proc_controller.sv
// =============================================================================
// Module   : proc_controller
// Summary  : Multi-cycle Init/Fetch/Decode/Execute control unit for the 16-bit
//            teaching processor. Holds PC and IR and drives ROM, data-memory,
//            register-file and ALU controls. Optional JMP support is enabled
//            by defining PROC_CTRL_JUMP_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module proc_controller #(
    parameter int              PC_W    = 8,
    parameter logic [PC_W-1:0] INIT_PC = 8'h00
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [15:0]     Instr,
    output logic [PC_W-1:0] I_Addr,
    output logic [15:0]     IR_Out,
    output logic [PC_W-1:0] PC_Out,
    output logic [3:0]      StateO,
    output logic [7:0]      D_Addr,
    output logic            D_Wr,
    output logic            RF_s,
    output logic [3:0]      RF_W_Addr,
    output logic            RF_W_en,
    output logic [3:0]      RF_Ra_Addr,
    output logic [3:0]      RF_Rb_Addr,
    output logic [2:0]      ALU_s0
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOADA  = 4'd4,
        S_LOADB  = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [PC_W-1:0]   r_pc;
    logic [15:0]       r_ir;

    logic [3:0]        w_op;
    logic [3:0]        w_ra;
    logic [3:0]        w_rb;
    logic [3:0]        w_rc;
    logic [7:0]        w_addr;

    assign w_op   = r_ir[15:12];
    assign w_ra   = r_ir[11:8];
    assign w_rb   = r_ir[7:4];
    assign w_rc   = r_ir[3:0];
    assign w_addr = r_ir[7:0];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_INIT;
            r_pc    <= INIT_PC;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH) begin
                r_ir <= Instr;
                r_pc <= r_pc + 1'b1;
            end
`ifdef PROC_CTRL_JUMP_EN
            // Jump target is taken as the PC leaves the Jump state.
            else if (r_state == S_JUMP) begin
                r_pc <= PC_W'(w_addr);
            end
`endif
        end
    end

    always_comb begin
        w_next_state = S_INIT;
        case (r_state)
            S_INIT:   w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    4'd1:    w_next_state = S_STORE;
                    4'd2:    w_next_state = S_LOADA;
                    4'd3:    w_next_state = S_ADD;
                    4'd4:    w_next_state = S_SUB;
                    4'd5:    w_next_state = S_HALT;
`ifdef PROC_CTRL_JUMP_EN
                    4'd6:    w_next_state = S_JUMP;
`endif
                    default: w_next_state = S_NOOP;
                endcase
            end
            S_LOADA:  w_next_state = S_LOADB;
            S_HALT:   w_next_state = S_HALT;
            S_NOOP, S_LOADB, S_STORE, S_ADD, S_SUB, S_JUMP:
                      w_next_state = S_FETCH;
            default:  w_next_state = S_INIT;
        endcase
    end

    // Moore outputs: depend only on the current state and IR.
    always_comb begin
        D_Addr     = 8'h00;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = 4'h0;
        RF_W_en    = 1'b0;
        RF_Ra_Addr = 4'h0;
        RF_Rb_Addr = 4'h0;
        ALU_s0     = 3'd0;
        case (r_state)
            S_LOADA: begin
                D_Addr = w_addr;
                RF_s   = 1'b1;
            end
            S_LOADB: begin
                D_Addr    = w_addr;
                RF_s      = 1'b1;
                RF_W_Addr = w_ra;
                RF_W_en   = 1'b1;
            end
            S_STORE: begin
                D_Addr     = w_addr;
                RF_Ra_Addr = w_ra;
                D_Wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_Addr = w_ra;
                RF_Rb_Addr = w_rb;
                RF_W_Addr  = w_rc;
                RF_W_en    = 1'b1;
                ALU_s0     = (r_state == S_ADD) ? 3'd1 : 3'd2;
            end
            default: ;
        endcase
    end

    assign I_Addr = r_pc;
    assign PC_Out = r_pc;
    assign IR_Out = r_ir;
    assign StateO = r_state;

endmodule

`default_nettype wire

// File: tb/tb_proc_controller.sv
// Scoreboard bench: an instruction-level program model builds the expected
// per-cycle trace; a negedge monitor pops and compares against the DUT.
`default_nettype none

module tb_proc_controller;

    typedef struct packed {
        logic [3:0]  st;
        logic [7:0]  pc;
        logic [15:0] ir;
        logic [7:0]  d_addr;
        logic        d_wr;
        logic        rf_s;
        logic [3:0]  w_addr;
        logic        w_en;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr;
    logic [7:0]  i_addr, pc_out, d_addr;
    logic [15:0] ir_out;
    logic [3:0]  state_o, rf_w_addr, rf_ra_addr, rf_rb_addr;
    logic        d_wr, rf_s, rf_w_en;
    logic [2:0]  alu_s0;

    logic [15:0] rom [256];
    obs_t        exp_q [$];
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    assign instr = rom[i_addr];

    proc_controller dut (
        .Clk        (clk),
        .Reset      (rst),
        .Instr      (instr),
        .I_Addr     (i_addr),
        .IR_Out     (ir_out),
        .PC_Out     (pc_out),
        .StateO     (state_o),
        .D_Addr     (d_addr),
        .D_Wr       (d_wr),
        .RF_s       (rf_s),
        .RF_W_Addr  (rf_w_addr),
        .RF_W_en    (rf_w_en),
        .RF_Ra_Addr (rf_ra_addr),
        .RF_Rb_Addr (rf_rb_addr),
        .ALU_s0     (alu_s0)
    );

    always #5 clk = ~clk;

    function automatic obs_t actual();
        obs_t a;
        a = '{st: state_o, pc: pc_out, ir: ir_out, d_addr: d_addr, d_wr: d_wr,
              rf_s: rf_s, w_addr: rf_w_addr, w_en: rf_w_en, ra: rf_ra_addr,
              rb: rf_rb_addr, alu: alu_s0};
        return a;
    endfunction

    function automatic obs_t idle(input logic [3:0] st, input logic [7:0] pc,
                                  input logic [15:0] ir);
        obs_t o;
        o    = '0;
        o.st = st;
        o.pc = pc;
        o.ir = ir;
        return o;
    endfunction

    // Program-level model: walks the ROM instruction by instruction and
    // emits the cycles each instruction is expected to occupy.
    task automatic gen_trace(input int n);
        logic [7:0]  pc;
        logic [15:0] ir;
        obs_t        o;
        bit          halted;
        pc = 8'h00;
        ir = 16'h0000;
        halted = 0;
        exp_q.delete();
        exp_q.push_back(idle(4'd0, pc, ir));
        while (exp_q.size() < n && !halted) begin
            exp_q.push_back(idle(4'd1, pc, ir));
            ir = rom[pc];
            pc = pc + 8'd1;
            exp_q.push_back(idle(4'd2, pc, ir));
            o = idle(4'd3, pc, ir);
            case (ir[15:12])
                4'd1: begin
                    o.st = 4'd6; o.d_addr = ir[7:0]; o.ra = ir[11:8]; o.d_wr = 1;
                    exp_q.push_back(o);
                end
                4'd2: begin
                    o.st = 4'd4; o.d_addr = ir[7:0]; o.rf_s = 1;
                    exp_q.push_back(o);
                    o.st = 4'd5; o.w_addr = ir[11:8]; o.w_en = 1;
                    exp_q.push_back(o);
                end
                4'd3, 4'd4: begin
                    o.st = (ir[15:12] == 4'd3) ? 4'd7 : 4'd8;
                    o.alu = (ir[15:12] == 4'd3) ? 3'd1 : 3'd2;
                    o.ra = ir[11:8]; o.rb = ir[7:4]; o.w_addr = ir[3:0]; o.w_en = 1;
                    exp_q.push_back(o);
                end
                4'd5: begin
                    o.st = 4'd9;
                    while (exp_q.size() < n) exp_q.push_back(o);
                    halted = 1;
                end
`ifdef PROC_CTRL_JUMP_EN
                4'd6: begin
                    o.st = 4'd10;
                    exp_q.push_back(o);
                    pc = ir[7:0];
                end
`endif
                default: exp_q.push_back(o);
            endcase
        end
        while (exp_q.size() > n) void'(exp_q.pop_back());
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (mon_en && !rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = actual();
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL trace cyc=%0d: got st=%0d pc=%h ir=%h da=%h dwr=%b rfs=%b wa=%h wen=%b ra=%h rb=%h alu=%0d, want st=%0d pc=%h ir=%h da=%h dwr=%b rfs=%b wa=%h wen=%b ra=%h rb=%h alu=%0d",
                         cyc, a.st, a.pc, a.ir, a.d_addr, a.d_wr, a.rf_s, a.w_addr, a.w_en, a.ra, a.rb, a.alu,
                         e.st, e.pc, e.ir, e.d_addr, e.d_wr, e.rf_s, e.w_addr, e.w_en, e.ra, e.rb, e.alu);
            end
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic run_prog(input int n);
        int budget;
        rst = 1'b1;
        gen_trace(n);
        cyc = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        budget = n + 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL timeout: got %0d pending, want 0", exp_q.size());
        end
        mon_en = 1'b0;
        rst    = 1'b1;
    endtask

    initial begin
        logic [15:0] w;
        int          budget;
        clear_rom();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_obs", 32'(actual() == '0), 32'd1);
        check("reset_state", 32'(state_o), 32'd0);

        // directed programs
        clear_rom();
        run_prog(12);
        clear_rom(); rom[0] = 16'h2310;
        run_prog(10);
        clear_rom(); rom[0] = 16'h3125; rom[1] = 16'h4125;
        run_prog(12);
        clear_rom(); rom[0] = 16'h1407; rom[1] = 16'h5000;
        run_prog(110);
        clear_rom(); rom[0] = 16'h6042;
        run_prog(12);
        clear_rom();
        run_prog(790);

        // randomized programs, HALT made rare so programs run longer
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) begin
                w = 16'($urandom);
                if (w[15:12] == 4'd5 && $urandom_range(0, 7) != 0) w[15:12] = 4'd0;
                rom[i] = w;
            end
            run_prog(250);
        end

        // asynchronous reset during the second Decode
        clear_rom();
        @(posedge clk);
        #1 rst = 1'b0;
        budget = 50;
        while (!(state_o == 4'd2 && pc_out == 8'd2) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("reach_decode", 32'(budget > 0), 32'd1);
        rom[1] = 16'hFFFF;
        #1 rst = 1'b1;
        #1;
        check("async_state", 32'(state_o), 32'd0);
        check("async_pc", 32'(pc_out), 32'd0);
        check("async_ir", 32'(ir_out), 32'd0);
        check("async_outs", 32'(actual() == '0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/proc_controller.md
# proc_controller

Multi-cycle control unit for the 16-bit teaching processor: holds the program counter and instruction register, and runs the Init/Fetch/Decode/Execute state machine. It drives the instruction-ROM address, data-memory controls, register-file addresses/enables and the ALU function select. Its `StateO`, `PC_Out` and `IR_Out` feed the board hex-display mux.

## Interface

Parameters:

- `PC_W`, 8: PC and instruction-ROM address width.
- `INIT_PC`, 8'h00: PC value loaded on reset.

Ports:

- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `Instr`  in  16  instruction-ROM read data; combinational read of `I_Addr`.
- `I_Addr`  out  8  instruction-ROM address (= `PC_Out`).
- `IR_Out`  out  16  instruction register.
- `PC_Out`  out  8  program counter.
- `StateO`  out  4  current state encoding.
- `D_Addr`  out  8  data-memory address.
- `D_Wr`  out  1  data-memory write enable.
- `RF_s`  out  1  register-file write-data select: 1 = memory, 0 = ALU.
- `RF_W_Addr`  out  4  register-file write address.
- `RF_W_en`  out  1  register-file write enable.
- `RF_Ra_Addr`  out  4  read-port A address.
- `RF_Rb_Addr`  out  4  read-port B address.
- `ALU_s0`  out  3  ALU function: 0 pass A, 1 add, 2 sub.

## Operation

Instruction fields:

- `op` = IR[15:12]; `ra` = IR[11:8]; `rb` = IR[7:4]; `rc` = IR[3:0]; `addr` = IR[7:0].
- Opcodes:
  - 0 NOOP.
  - 1 STORE: mem[addr] <= R[ra].
  - 2 LOAD: R[ra] <= mem[addr].
  - 3 ADD: R[rc] <= R[ra] + R[rb].
  - 4 SUB: R[rc] <= R[ra] − R[rb].
  - 5 HALT.
  - 6 JMP (configurable, see Configuration).
  - 7–15 execute as NOOP.

States and `StateO` encoding:

- Init=0, Fetch=1, Decode=2, NoOp=3, LoadA=4, LoadB=5, Store=6, Add=7, Sub=8, Halt=9, Jump=10.

Transitions:

- Init → Fetch.
- Fetch → Decode; on this edge IR <= `Instr` and PC <= PC+1.
- Decode → the state selected by `op`.
- LoadA → LoadB.
- NoOp, LoadB, Store, Add, Sub, Jump → Fetch.
- Halt → Halt until `Reset`.

Outputs are Moore-style: a function of state and IR only. Any output not listed for a state is 0.

- LoadA: `D_Addr`=addr, `RF_s`=1.
- LoadB: `D_Addr`=addr, `RF_s`=1, `RF_W_Addr`=ra, `RF_W_en`=1.
- Store: `D_Addr`=addr, `RF_Ra_Addr`=ra, `D_Wr`=1.
- Add: `RF_Ra_Addr`=ra, `RF_Rb_Addr`=rb, `RF_W_Addr`=rc, `ALU_s0`=1, `RF_W_en`=1.
- Sub: as Add, but `ALU_s0`=2.

Arithmetic and boundary rules:

- PC increments modulo 256; 8'hFF wraps to 8'h00 with no flag.
- Reset mid-instruction aborts it. A partial LOAD leaves the register file unwritten, because `RF_W_en` only asserts in LoadB.
- Unused opcodes never assert `D_Wr` or `RF_W_en`.

## Timing

Reset values:

- state=Init, PC=`INIT_PC`, IR=16'h0000.
- `StateO`=0; all enables 0, all addresses 0, `ALU_s0`=0.

Latency (cycles from Fetch entry to the next Fetch entry):

- NOOP, STORE, ADD, SUB, JMP: 3.
- LOAD: 4. Data memory has synchronous read, so read data is valid in LoadB.
- After reset deassertion, the first Fetch occurs 1 cycle later (via Init).

Write timing:

- Register-file and data-memory writes take effect on the rising edge that exits the execute state.
- `IR_Out` and `PC_Out` change only on the Fetch→Decode edge (or a JMP edge). Display contents are therefore stable for the rest of the instruction.

## Configuration

- `PROC_CTRL_JUMP_EN` defined:
  - op 6 → Jump state.
  - PC <= addr on the Jump→Fetch edge.
  - `StateO`=10 while in Jump.
- Not defined:
  - op 6 decodes to NoOp.
  - State 10 is unreachable.
  - PC behaves as for any NOOP.

## Test plan

- Reset held, then released with ROM[0]=16'h0000 → `StateO` sequence 0,1,2,3,1. `PC_Out` becomes 1 after the first Fetch; `IR_Out`=16'h0000.
- ROM[0]=16'h2310 (LOAD R3 ← mem[16]) → states 1,2,4,5. `D_Addr`=8'h10 in both; `RF_W_en`=1 with `RF_W_Addr`=3 only in state 5; `RF_s`=1.
- ROM[0]=16'h3125 (ADD R5=R1+R2), then 16'h4125 → state 7 with Ra=1, Rb=2, W=5, `ALU_s0`=1. Next instruction: state 8 with `ALU_s0`=2.
- ROM[0]=16'h1407 (STORE), ROM[1]=16'h5000 (HALT) → `D_Wr`=1 for exactly 1 cycle with `D_Addr`=7 and Ra=4. Then `StateO` stays 9 for 100 cycles and `PC_Out` stays 2.
- ROM filled with NOOP → PC steps 8'hFE, 8'hFF, 8'h00. `Reset` asserted during Decode → `StateO`=0, PC=0 asynchronously, before the next edge.
- ROM[0]=16'h6042 → with `PROC_CTRL_JUMP_EN`: `StateO`=10, then `PC_Out`=8'h42. Without: `StateO`=3, then `PC_Out`=1.
